pi_system: RTL and testbench

Priority-interrupt (PI) controller sitting directly downstream of the APR device. It merges the APR's 7-level request vector with synchronised Unibus adapter requests and the microcode program requests, and arbitrates by level (1 highest, 7 lowest) against the levels already in progress. It raises an interrupt request to the microsequencer and tracks in-progress levels through acknowledge and dismiss strobes. It also returns the CONI PI status word to the datapath.

---
 rtl/pi_system.sv | 173 +++++++++++++++++
 tb/tb_pi_system.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_system.sv
// Priority-interrupt controller: merges APR, Unibus and program requests,
// arbitrates by level against in-progress levels and drives the microsequencer.
module pi_system #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic [0:35] dp,
  input  logic        piLOAD,
  input  logic        piACK,
  input  logic        piDISMISS,
  input  logic [1:7]  apr_pi_req,
  input  logic [1:7]  bus_pi_req,
  output logic        pi_req,
  output logic [0:2]  pi_new_level,
  output logic [0:2]  pi_cur_level,
  output logic [0:35] pi_status
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, REQ = 2'd2} piState_t;

  function automatic logic [2:0] lowestLevel(input logic [1:7] v);
    logic [2:0] lev;
    lev = '0;
    for (int n = 7; n >= 1; n--) begin
      if (v[n]) lev = 3'(n);
    end
    return lev;
  endfunction

  function automatic logic [1:7] levelMask(input logic [2:0] lev);
    logic [1:7] m;
    m = '0;
    for (int n = 1; n <= 7; n++) begin
      if (lev == 3'(n)) m[n] = 1'b1;
    end
    return m;
  endfunction

  piState_t state;
  logic [1:7] progREQ, inPROG, levEN;
  logic       piON;
  logic [2:0] newLEV;
  logic       piReqReg;
  logic [2:0] newLevOut;

  logic [SYNC_STAGES-1:0][1:7] syncChain;
  logic [1:7] syncBus;

  logic [1:7] pend;
  logic [2:0] best, curLevel;
  logic       qualifies, latchedQual;
  logic       cono, conoClr;
  logic [1:7] levSel;
  logic [1:7] progNext, enNext, inProgNext, ackMask, dismissMask;
  logic       onNext;
  logic       unusedDp;

  // Bus requests are asynchronous; the chain runs regardless of clken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncChain <= '0;
    end else begin
      syncChain[0] <= bus_pi_req;
      for (int s = 1; s < SYNC_STAGES; s++) syncChain[s] <= syncChain[s-1];
    end
  end
  assign syncBus = syncChain[SYNC_STAGES-1];

  assign curLevel    = lowestLevel(inPROG);
  assign pend        = (syncBus | apr_pi_req | progREQ) & levEN & {7{piON}};
  assign best        = lowestLevel(pend);
  assign qualifies   = (best != 3'd0) && ((curLevel == 3'd0) || (best < curLevel));
  assign latchedQual = (|(pend & levelMask(newLEV))) &&
                       ((curLevel == 3'd0) || (newLEV < curLevel));

  assign cono     = clken & piLOAD;
  assign conoClr  = cono & dp[23];
  assign levSel   = dp[29:35];
  assign unusedDp = ^dp[0:21];

  always_comb begin
    progNext    = progREQ;
    enNext      = levEN;
    onNext      = piON;
    if (cono) begin
      if (dp[24]) progNext = progNext | levSel;
      if (dp[22]) progNext = progNext & ~levSel;
      if (dp[25]) enNext = enNext | levSel;
      if (dp[26]) enNext = enNext & ~levSel;
      if (dp[28]) onNext = 1'b1;
      if (dp[27]) onNext = 1'b0;
    end
    // Dismiss acts on the pre-cycle in-progress set, then the ack bit lands.
    ackMask     = (state == REQ && piACK) ? levelMask(newLEV) : '0;
    dismissMask = piDISMISS ? levelMask(curLevel) : '0;
    inProgNext  = (inPROG & ~dismissMask) | ackMask;
    if (conoClr) begin
      progNext   = '0;
      enNext     = '0;
      onNext     = 1'b0;
      inProgNext = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      progREQ   <= '0;
      inPROG    <= '0;
      levEN     <= '0;
      piON      <= 1'b0;
      newLEV    <= '0;
      piReqReg  <= 1'b0;
      newLevOut <= '0;
    end else if (clken) begin
      progREQ <= progNext;
      inPROG  <= inProgNext;
      levEN   <= enNext;
      piON    <= onNext;
      if (conoClr) begin
        state     <= IDLE;
        piReqReg  <= 1'b0;
        newLevOut <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (qualifies) begin
              newLEV <= best;
              state  <= ARB;
            end
          end
          ARB: begin
            if (latchedQual) begin
              state     <= REQ;
              piReqReg  <= 1'b1;
              newLevOut <= newLEV;
            end else begin
              state <= IDLE;
            end
          end
          REQ: begin
            // A better newcomer never preempts; it is picked up after the ack.
            if (piACK || !latchedQual) begin
              state     <= IDLE;
              piReqReg  <= 1'b0;
              newLevOut <= '0;
            end
          end
          default: begin
            state     <= IDLE;
            piReqReg  <= 1'b0;
            newLevOut <= '0;
          end
        endcase
      end
    end
  end

  assign pi_req       = piReqReg;
  assign pi_new_level = newLevOut;
  assign pi_cur_level = curLevel;

  always_comb begin
    pi_status        = '0;
    pi_status[11:17] = progREQ;
    pi_status[21:27] = inPROG;
    pi_status[28]    = piON;
    pi_status[29:35] = levEN;
  end

endmodule

// File: tb/tb_pi_system.sv
// Self-checking bench for pi_system: directed scenarios plus randomized
// request/ack/dismiss traffic against a level-set reference model.
module tb_pi_system;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clken = 1'b1;
  logic [0:35] dp = '0;
  logic        piLOAD = 1'b0, piACK = 1'b0, piDISMISS = 1'b0;
  logic [1:7]  apr_pi_req = '0, bus_pi_req = '0;
  logic        pi_req;
  logic [0:2]  pi_new_level, pi_cur_level;
  logic [0:35] pi_status;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit [1:7] mProg, mInProg, mEn;
  bit       mOn;

  pi_system #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .clken(clken), .dp(dp), .piLOAD(piLOAD),
    .piACK(piACK), .piDISMISS(piDISMISS), .apr_pi_req(apr_pi_req),
    .bus_pi_req(bus_pi_req), .pi_req(pi_req), .pi_new_level(pi_new_level),
    .pi_cur_level(pi_cur_level), .pi_status(pi_status)
  );

  always #5 clk = ~clk;

  function automatic int lowest(input bit [1:7] v);
    for (int n = 1; n <= 7; n++) if (v[n]) return n;
    return 0;
  endfunction

  function automatic logic [0:35] statusWord();
    logic [0:35] s;
    s = '0;
    s[11:17] = mProg;
    s[21:27] = mInProg;
    s[28]    = mOn;
    s[29:35] = mEn;
    return s;
  endfunction

  function automatic logic [0:35] mkCono(input bit clr, setR, dropR, en, dis,
                                         on, off, input logic [1:7] lev);
    logic [0:35] w;
    w = '0;
    w[23] = clr; w[24] = setR; w[22] = dropR; w[25] = en; w[26] = dis;
    w[28] = on;  w[27] = off;  w[29:35] = lev;
    return w;
  endfunction

  function automatic bit [1:7] lvBit(input int n);
    bit [1:7] m;
    m = '0;
    if (n >= 1 && n <= 7) m[n] = 1'b1;
    return m;
  endfunction

  task automatic modelReset();
    mProg = '0; mInProg = '0; mEn = '0; mOn = 1'b0;
  endtask

  task automatic modelCono(input logic [0:35] w);
    bit [1:7] lev;
    lev = w[29:35];
    if (w[23]) begin
      modelReset();
    end else begin
      if (w[24]) mProg = mProg | lev;
      if (w[22]) mProg = mProg & ~lev;
      if (w[25]) mEn = mEn | lev;
      if (w[26]) mEn = mEn & ~lev;
      if (w[28]) mOn = 1'b1;
      if (w[27]) mOn = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doCono(input logic [0:35] w);
    dp = w; piLOAD = 1'b1;
    tick();
    piLOAD = 1'b0; dp = '0;
    modelCono(w);
  endtask

  task automatic doAck(input int lev);
    piACK = 1'b1;
    tick();
    piACK = 1'b0;
    mInProg = mInProg | lvBit(lev);
  endtask

  task automatic doDismiss();
    piDISMISS = 1'b1;
    tick();
    piDISMISS = 1'b0;
    mInProg = mInProg & ~lvBit(lowest(mInProg));
  endtask

  task automatic waitReq(input int maxTicks, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxTicks; i++) begin
      tick();
      if (pi_req === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", pi_req); end
    checks++; if (pi_new_level !== 3'd0) begin errors++; $display("FAIL reset_new got %0d want 0", pi_new_level); end
    checks++; if (pi_cur_level !== 3'd0) begin errors++; $display("FAIL reset_cur got %0d want 0", pi_cur_level); end
    checks++; if (pi_status !== 36'd0) begin errors++; $display("FAIL reset_status got %o want 0", pi_status); end
    rst = 1'b0;
    tick();
    $display("reset: done");
  endtask

  task automatic test_apr_ack();
    doCono(36'o000000_002377);
    checks++; if (pi_status !== statusWord()) begin errors++; $display("FAIL cono_on got %o want %o", pi_status, statusWord()); end
    apr_pi_req = 7'b0001000;
    tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL apr_arb_req got %b want 0", pi_req); end
    tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd4) begin
      errors++; $display("FAIL apr_req got req=%b lvl=%0d want req=1 lvl=4", pi_req, pi_new_level); end
    doAck(4);
    apr_pi_req = '0;
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL apr_ack_req got %b want 0", pi_req); end
    checks++; if (pi_cur_level !== 3'd4) begin errors++; $display("FAIL apr_ack_cur got %0d want 4", pi_cur_level); end
    checks++; if (pi_status[24] !== 1'b1 || pi_status !== statusWord()) begin
      errors++; $display("FAIL apr_ack_status got %o want %o", pi_status, statusWord()); end
    $display("apr_ack: level 4 requested and acknowledged");
  endtask

  task automatic test_bus();
    bus_pi_req = 7'b0100000;
    apr_pi_req = 7'b0000010;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL bus_early tick=%0d got %b want 0", i, pi_req); end
    end
    tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd2) begin
      errors++; $display("FAIL bus_req got req=%b lvl=%0d want req=1 lvl=2", pi_req, pi_new_level); end
    doAck(2);
    bus_pi_req = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL bus_lvl6_blocked got %b want 0", pi_req); end
    end
    doDismiss();
    checks++; if (pi_cur_level !== 3'd4) begin errors++; $display("FAIL bus_dismiss1 got %0d want 4", pi_cur_level); end
    doDismiss();
    apr_pi_req = '0;
    checks++; if (pi_cur_level !== 3'd0) begin errors++; $display("FAIL bus_dismiss2 got %0d want 0", pi_cur_level); end
    tick(); tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL bus_idle got %b want 0", pi_req); end
    $display("bus: level 2 via synchroniser, level 6 held off");
  endtask

  task automatic test_withdraw();
    apr_pi_req = 7'b0010000;
    tick(); tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd3) begin
      errors++; $display("FAIL wd_req got req=%b lvl=%0d want req=1 lvl=3", pi_req, pi_new_level); end
    doCono(mkCono(0, 0, 0, 0, 1, 0, 0, 7'b0010000));
    tick();
    checks++; if (pi_req !== 1'b0 || pi_new_level !== 3'd0) begin
      errors++; $display("FAIL wd_withdraw got req=%b lvl=%0d want req=0 lvl=0", pi_req, pi_new_level); end
    doCono(mkCono(0, 0, 0, 1, 0, 0, 0, 7'b0010000));
    tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL wd_rearb got %b want 0", pi_req); end
    tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd3) begin
      errors++; $display("FAIL wd_rereq got req=%b lvl=%0d want req=1 lvl=3", pi_req, pi_new_level); end
    apr_pi_req = '0;
    tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL wd_gone got %b want 0", pi_req); end
    $display("withdraw: level 3 withdrawn on disable");
  endtask

  task automatic test_progreq();
    doCono(mkCono(0, 1, 0, 0, 0, 0, 0, 7'b0000001));
    checks++; if (pi_status[17] !== 1'b1 || pi_status !== statusWord()) begin
      errors++; $display("FAIL prog_set got %o want %o", pi_status, statusWord()); end
    tick(); tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd7) begin
      errors++; $display("FAIL prog_req got req=%b lvl=%0d want req=1 lvl=7", pi_req, pi_new_level); end
    doAck(7);
    checks++; if (pi_cur_level !== 3'd7) begin errors++; $display("FAIL prog_cur got %0d want 7", pi_cur_level); end
    doCono(mkCono(0, 0, 1, 0, 0, 0, 0, 7'b0000001));
    checks++; if (pi_status !== statusWord()) begin errors++; $display("FAIL prog_drop got %o want %o", pi_status, statusWord()); end
    doDismiss();
    checks++; if (pi_cur_level !== 3'd0 || pi_status !== statusWord()) begin
      errors++; $display("FAIL prog_dismiss got cur=%0d st=%o want cur=0 st=%o", pi_cur_level, pi_status, statusWord()); end
    $display("progreq: program level 7 set, acked, dropped, dismissed");
  endtask

  task automatic test_dismiss_ack();
    bit seen;
    int levs[3] = '{5, 2, 1};
    foreach (levs[i]) begin
      apr_pi_req = lvBit(levs[i]);
      waitReq(6, seen);
      checks++; if (!seen || pi_new_level !== 3'(levs[i])) begin
        errors++; $display("FAIL da_req got seen=%b lvl=%0d want lvl=%0d", seen, pi_new_level, levs[i]); end
      if (i < 2) doAck(levs[i]);
    end
    piACK = 1'b1; piDISMISS = 1'b1;
    tick();
    piACK = 1'b0; piDISMISS = 1'b0;
    apr_pi_req = '0;
    mInProg = (mInProg & ~lvBit(lowest(mInProg))) | lvBit(1);
    checks++; if (pi_status[21:27] !== 7'b1000100 || pi_status !== statusWord()) begin
      errors++; $display("FAIL da_inprog got %b want 1000100", pi_status[21:27]); end
    checks++; if (pi_cur_level !== 3'd1) begin errors++; $display("FAIL da_cur got %0d want 1", pi_cur_level); end
    $display("dismiss_ack: inPROG now levels 1 and 5");
  endtask

  task automatic test_clear();
    bit seen;
    doDismiss();
    apr_pi_req = lvBit(3);
    waitReq(6, seen);
    checks++; if (!seen || pi_new_level !== 3'd3) begin
      errors++; $display("FAIL clr_pre got seen=%b lvl=%0d want lvl=3", seen, pi_new_level); end
    dp = mkCono(1, 1, 0, 1, 0, 1, 0, 7'b1111111);
    piLOAD = 1'b1; piACK = 1'b1; piDISMISS = 1'b1;
    tick();
    piLOAD = 1'b0; piACK = 1'b0; piDISMISS = 1'b0; dp = '0;
    modelReset();
    checks++; if (pi_status !== 36'd0) begin errors++; $display("FAIL clr_status got %o want 0", pi_status); end
    checks++; if (pi_req !== 1'b0 || pi_new_level !== 3'd0 || pi_cur_level !== 3'd0) begin
      errors++; $display("FAIL clr_outs got req=%b new=%0d cur=%0d want 0 0 0", pi_req, pi_new_level, pi_cur_level); end
    tick(); tick(); tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL clr_stays got %b want 0", pi_req); end
    apr_pi_req = '0;
    $display("clear: CONO clear wiped the PI system");
  endtask

  task automatic test_async_reset();
    doCono(36'o000000_002377);
    apr_pi_req = lvBit(2);
    tick(); tick();
    checks++; if (pi_req !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", pi_req); end
    #2 rst = 1'b1;
    #1;
    modelReset();
    checks++; if (pi_req !== 1'b0 || pi_new_level !== 3'd0) begin
      errors++; $display("FAIL ar_req got req=%b lvl=%0d want 0 0", pi_req, pi_new_level); end
    checks++; if (pi_status !== 36'd0 || pi_cur_level !== 3'd0) begin
      errors++; $display("FAIL ar_status got %o cur=%0d want 0", pi_status, pi_cur_level); end
    apr_pi_req = '0;
    tick();
    rst = 1'b0;
    tick();
    $display("async_reset: pi_req dropped without a clock edge");
  endtask

  task automatic test_clken();
    doCono(36'o000000_002377);
    clken = 1'b0;
    apr_pi_req = lvBit(4);
    dp = mkCono(0, 1, 0, 0, 0, 0, 1, 7'b1000000);
    piLOAD = 1'b1;
    tick();
    piLOAD = 1'b0; dp = '0;
    tick(); tick(); tick();
    checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL ce_req got %b want 0", pi_req); end
    checks++; if (pi_status !== statusWord()) begin errors++; $display("FAIL ce_hold got %o want %o", pi_status, statusWord()); end
    clken = 1'b1;
    tick(); tick();
    checks++; if (pi_req !== 1'b1 || pi_new_level !== 3'd4) begin
      errors++; $display("FAIL ce_resume got req=%b lvl=%0d want 1 4", pi_req, pi_new_level); end
    apr_pi_req = '0;
    tick();
    $display("clken: state held while clken low");
  endtask

  task automatic test_random();
    bit seen, on;
    bit [1:7] rEn, rProg, rApr, pendM;
    int b, c;
    for (int it = 0; it < 24; it++) begin
      apr_pi_req = '0;
      on = ($urandom_range(0, 7) != 0);
      doCono(mkCono(0, 0, 1, 0, 1, on, !on, 7'b1111111));
      tick(); tick();
      checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL rnd_quiet it=%0d got %b want 0", it, pi_req); end
      rEn   = 7'($urandom);
      rProg = 7'($urandom) & 7'($urandom) & 7'($urandom);
      rApr  = 7'($urandom) & 7'($urandom);
      doCono(mkCono(0, 0, 0, 1, 0, 0, 0, rEn));
      doCono(mkCono(0, 1, 0, 0, 0, 0, 0, rProg));
      apr_pi_req = rApr;
      pendM = (rApr | mProg) & mEn & {7{mOn}};
      b = lowest(pendM);
      c = lowest(mInProg);
      waitReq(6, seen);
      if (b != 0 && (c == 0 || b < c)) begin
        checks++; if (!seen || pi_new_level !== 3'(b)) begin
          errors++; $display("FAIL rnd_req it=%0d got seen=%b lvl=%0d want lvl=%0d", it, seen, pi_new_level, b); end
        doAck(b);
        checks++; if (pi_req !== 1'b0) begin errors++; $display("FAIL rnd_ackdrop it=%0d got %b want 0", it, pi_req); end
      end else begin
        checks++; if (seen) begin errors++; $display("FAIL rnd_noreq it=%0d got lvl=%0d want none", it, pi_new_level); end
      end
      checks++; if (pi_cur_level !== 3'(lowest(mInProg)) || pi_status !== statusWord()) begin
        errors++; $display("FAIL rnd_state it=%0d got cur=%0d st=%o want cur=%0d st=%o",
                           it, pi_cur_level, pi_status, lowest(mInProg), statusWord()); end
      if ($urandom_range(0, 1) == 1) doDismiss();
      $display("random it=%0d apr=%b prog=%b en=%b on=%b expect=%0d inprog=%b",
               it, rApr, rProg, rEn, on, (b != 0 && (c == 0 || b < c)) ? b : 0, mInProg);
    end
    apr_pi_req = '0;
  endtask

  initial begin
    modelReset();
    test_reset();
    test_apr_ack();
    test_bus();
    test_withdraw();
    test_progreq();
    test_dismiss_ack();
    test_clear();
    test_async_reset();
    test_clken();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
